// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM plane arbiter.
// Lane packing of mem_q / gfx_data is {bg3,bg2,bg1,fg3,fg2,fg1}, plane FG1 in the low byte.
package vram_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned PLANES = 6;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned Q_W    = PLANES * LANE_W;

    localparam int unsigned FG1 = 0;
    localparam int unsigned FG2 = 1;
    localparam int unsigned FG3 = 2;
    localparam int unsigned BG1 = 3;
    localparam int unsigned BG2 = 4;
    localparam int unsigned BG3 = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GFX_ISSUE,
        ST_GFX_CAPT,
        ST_CPU_ISSUE,
        ST_CPU_CAPT,
        ST_ACK
    } state_t;

    // Request attributes that must survive past the issue cycle
    typedef struct packed {
        logic       cpu;
        logic       wr;
        logic [7:0] rd_bank;
    } grant_t;

    function automatic logic [LANE_W-1:0] plane_lane(input logic [Q_W-1:0] q, input int unsigned idx);
        return q[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU port, gfx fetch port and shared VRAM plane port of the arbiter.
// slave = arbiter side, master = requesters plus plane memory.
interface vram_arbiter_if;
    import vram_pkg::*;

    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        rd_bank;
    logic [PLANES-1:0] wr_mask;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;
    logic              cpu_wait_n;

    logic              gfx_req;
    logic [ADDR_W-1:0] gfx_addr;
    logic              gfx_ack;
    logic [Q_W-1:0]    gfx_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we_n;
    logic [PLANES-1:0] mem_ce_n;
    logic [Q_W-1:0]    mem_q;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_din, rd_bank, wr_mask,
        input  gfx_req, gfx_addr, mem_q,
        output cpu_dout, cpu_ack, cpu_wait_n, gfx_ack, gfx_data,
        output mem_addr, mem_din, mem_we_n, mem_ce_n
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_din, rd_bank, wr_mask,
        output gfx_req, gfx_addr, mem_q,
        input  cpu_dout, cpu_ack, cpu_wait_n, gfx_ack, gfx_data,
        input  mem_addr, mem_din, mem_we_n, mem_ce_n
    );

endinterface

// File: rtl/vram_bank_decode.sv
// Read-bank decode: bank 1..6 -> one plane enabled (active-low CE), else none.
module vram_bank_decode
    import vram_pkg::*;
(
    input  logic [7:0]        bank,
    output logic [PLANES-1:0] ce_n,
    output logic              valid
);

    always_comb begin
        ce_n  = '1;
        valid = 1'b0;
        for (int unsigned i = 0; i < PLANES; i++) begin
            if (bank == 8'(i + 1)) begin
                ce_n[i] = 1'b0;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Time-multiplexes the six VRAM planes between the Z80 port and gfx scanout fetch.
// Optional CPU anti-starvation counter enabled by defining VRAM_ARB_FAIR_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset,
    vram_arbiter_if.slave bus
);

    state_t            state, state_d;
    grant_t            grant_q, grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              mem_we_n_q, mem_we_n_d;
    logic [PLANES-1:0] mem_ce_n_q, mem_ce_n_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              gfx_ack_q, gfx_ack_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic [Q_W-1:0]    gfx_data_q, gfx_data_d;

    logic              grant_gfx, grant_cpu, cpu_force;
    logic [7:0]        dec_bank;
    logic [PLANES-1:0] dec_ce_n;
    logic              dec_valid;
    logic [7:0]        cpu_lane;

    // Live bank while choosing the CE pattern, latched bank for the capture mux
    assign dec_bank = (state == ST_IDLE) ? bus.rd_bank : grant_q.rd_bank;

    vram_bank_decode u_bank_decode (
        .bank  (dec_bank),
        .ce_n  (dec_ce_n),
        .valid (dec_valid)
    );

    assign grant_gfx = (state == ST_IDLE) && bus.gfx_req && !(cpu_force && bus.cpu_req);
    assign grant_cpu = (state == ST_IDLE) && bus.cpu_req && !grant_gfx;

`ifdef VRAM_ARB_FAIR_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign cpu_force = (starve_q == CNT_W'(STARVE_LIMIT));

    // Count gfx wins that left a CPU request waiting
    always_comb begin
        starve_d = starve_q;
        if (grant_cpu) begin
            starve_d = '0;
        end else if (grant_gfx) begin
            starve_d = bus.cpu_req ? starve_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign cpu_force = 1'b0;
`endif

    // Byte of the single enabled plane; no plane enabled reads as FF
    always_comb begin
        cpu_lane = '0;
        for (int unsigned i = 0; i < PLANES; i++) begin
            if (!dec_ce_n[i]) begin
                cpu_lane = cpu_lane | plane_lane(bus.mem_q, i);
            end
        end
        if (!dec_valid) begin
            cpu_lane = 8'hFF;
        end
    end

    always_comb begin
        state_d    = state;
        grant_d    = grant_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_n_d = 1'b1;
        mem_ce_n_d = '1;
        cpu_ack_d  = 1'b0;
        gfx_ack_d  = 1'b0;
        cpu_dout_d = cpu_dout_q;
        gfx_data_d = gfx_data_q;

        unique case (state)
            ST_IDLE: begin
                if (grant_gfx) begin
                    state_d    = ST_GFX_ISSUE;
                    grant_d    = '0;
                    mem_addr_d = bus.gfx_addr;
                    mem_ce_n_d = '0;
                end else if (grant_cpu) begin
                    state_d    = ST_CPU_ISSUE;
                    grant_d    = '{cpu: 1'b1, wr: bus.cpu_wr, rd_bank: bus.rd_bank};
                    mem_addr_d = bus.cpu_addr;
                    if (bus.cpu_wr) begin
                        mem_we_n_d = 1'b0;
                        mem_ce_n_d = ~bus.wr_mask;
                        mem_din_d  = bus.cpu_din;
                    end else begin
                        mem_ce_n_d = dec_ce_n;
                    end
                end
            end
            ST_GFX_ISSUE: state_d = ST_GFX_CAPT;
            ST_GFX_CAPT: begin
                state_d    = ST_ACK;
                gfx_data_d = bus.mem_q;
                gfx_ack_d  = 1'b1;
            end
            ST_CPU_ISSUE: begin
                if (grant_q.wr) begin
                    state_d   = ST_ACK;
                    cpu_ack_d = 1'b1;
                end else begin
                    state_d = ST_CPU_CAPT;
                end
            end
            ST_CPU_CAPT: begin
                state_d    = ST_ACK;
                cpu_dout_d = cpu_lane;
                cpu_ack_d  = 1'b1;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_n_q <= 1'b1;
            mem_ce_n_q <= '1;
            cpu_ack_q  <= 1'b0;
            gfx_ack_q  <= 1'b0;
            cpu_dout_q <= 8'hFF;
            gfx_data_q <= '0;
        end else begin
            state      <= state_d;
            grant_q    <= grant_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_n_q <= mem_we_n_d;
            mem_ce_n_q <= mem_ce_n_d;
            cpu_ack_q  <= cpu_ack_d;
            gfx_ack_q  <= gfx_ack_d;
            cpu_dout_q <= cpu_dout_d;
            gfx_data_q <= gfx_data_d;
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.mem_we_n   = mem_we_n_q;
    assign bus.mem_ce_n   = mem_ce_n_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.gfx_ack    = gfx_ack_q;
    assign bus.cpu_dout   = cpu_dout_q;
    assign bus.gfx_data   = gfx_data_q;
    assign bus.cpu_wait_n = !(bus.cpu_req && !cpu_ack_q);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: plane memory model, reference model of plane contents,
// and a negedge monitor that pops expected acks and port activity.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vram_arbiter_if bus();

    vram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit         rd;
        logic [7:0] data;
    } cpu_exp_t;

    typedef struct {
        logic              we_n;
        logic [PLANES-1:0] ce_n;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
    } port_exp_t;

    int total = 0;
    int bad   = 0;

    logic [7:0] vram    [PLANES][2**ADDR_W];
    logic [7:0] ref_mem [PLANES][2**ADDR_W];

    cpu_exp_t          cpu_q[$];
    logic [Q_W-1:0]    gfx_q[$];
    port_exp_t         cpu_port_q[$];
    logic [ADDR_W-1:0] gfx_port_q[$];

    bit                hold_mode = 0;
    logic [ADDR_W-1:0] hold_addr;
    logic [Q_W-1:0]    hold_exp;

    int lat_c, lat_g, n_gfx;
    bit got_cpu;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [Q_W-1:0] gfx_ref(input logic [ADDR_W-1:0] a);
        return {ref_mem[BG3][a], ref_mem[BG2][a], ref_mem[BG1][a],
                ref_mem[FG3][a], ref_mem[FG2][a], ref_mem[FG1][a]};
    endfunction

    // Plane memory: writes on issue, read data one cycle later, junk otherwise
    always @(posedge clk) begin
        logic [Q_W-1:0] q;
        q = Q_W'({$urandom, $urandom});
        for (int i = 0; i < int'(PLANES); i++) begin
            if (!bus.mem_ce_n[i]) begin
                if (!bus.mem_we_n) vram[i][bus.mem_addr] = bus.mem_din;
                else               q[i*8 +: 8] = vram[i][bus.mem_addr];
            end
        end
        bus.mem_q <= q;
    end

    task automatic cpu_op(input bit wr, input logic [ADDR_W-1:0] addr, input logic [7:0] din,
                          input logic [7:0] bank, input logic [PLANES-1:0] mask,
                          input bit scramble, output int lat);
        cpu_exp_t  e;
        port_exp_t p;
        int        b;
        @(posedge clk); #1;
        bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_din = din;
        bus.rd_bank = bank; bus.wr_mask = mask; bus.cpu_req = 1'b1;
        b = int'(bank);
        e.rd   = !wr;
        e.data = (!wr && b >= 1 && b <= 6) ? ref_mem[b-1][addr] : 8'hFF;
        cpu_q.push_back(e);
        p.we_n = !wr; p.addr = addr; p.din = din;
        if (wr) begin
            for (int i = 0; i < int'(PLANES); i++) if (mask[i]) ref_mem[i][addr] = din;
            p.ce_n = ~mask;
            cpu_port_q.push_back(p);
        end else if (b >= 1 && b <= 6) begin
            p.ce_n = '1;
            p.ce_n[b-1] = 1'b0;
            cpu_port_q.push_back(p);
        end
        lat = 0;
        forever begin
            @(negedge clk); lat++;
            if (scramble && lat == 2) begin
                bus.rd_bank = 8'($urandom); bus.wr_mask = PLANES'($urandom);
                bus.cpu_addr = ADDR_W'($urandom); bus.cpu_din = 8'($urandom);
            end
            if (bus.cpu_ack) break;
            if (lat >= 200) begin chk("cpu_ack timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic gfx_op(input logic [ADDR_W-1:0] addr, output int lat);
        @(posedge clk); #1;
        bus.gfx_addr = addr; bus.gfx_req = 1'b1;
        gfx_q.push_back(gfx_ref(addr));
        gfx_port_q.push_back(addr);
        lat = 0;
        forever begin
            @(negedge clk); lat++;
            if (bus.gfx_ack) break;
            if (lat >= 200) begin chk("gfx_ack timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        bus.gfx_req = 1'b0;
    endtask

    // Monitor: stall rule, acks against scoreboard, plane port activity
    initial begin
        cpu_exp_t  e;
        port_exp_t p;
        forever begin
            @(negedge clk);
            if (reset) continue;
            chk("cpu_wait_n", bus.cpu_wait_n, !(bus.cpu_req && !bus.cpu_ack));
            if (bus.cpu_ack) begin
                if (cpu_q.size() == 0) chk("cpu_ack unexpected", 1, 0);
                else begin
                    e = cpu_q.pop_front();
                    if (e.rd) chk("cpu_dout", bus.cpu_dout, e.data);
                end
            end
            if (bus.gfx_ack) begin
                if (hold_mode) chk("gfx_data hold", bus.gfx_data, hold_exp);
                else if (gfx_q.size() == 0) chk("gfx_ack unexpected", 1, 0);
                else chk("gfx_data", bus.gfx_data, gfx_q.pop_front());
            end
            if (bus.mem_ce_n != '1 || !bus.mem_we_n) begin
                if (bus.mem_we_n && bus.mem_ce_n == '0) begin
                    if (hold_mode) chk("gfx port addr hold", bus.mem_addr, hold_addr);
                    else if (gfx_port_q.size() == 0) chk("gfx port unexpected", 1, 0);
                    else chk("gfx port addr", bus.mem_addr, gfx_port_q.pop_front());
                end else if (cpu_port_q.size() == 0) begin
                    chk("cpu port unexpected", 1, 0);
                end else begin
                    p = cpu_port_q.pop_front();
                    chk("cpu port we_n", bus.mem_we_n, p.we_n);
                    chk("cpu port ce_n", bus.mem_ce_n, p.ce_n);
                    chk("cpu port addr", bus.mem_addr, p.addr);
                    if (!p.we_n) chk("cpu port din", bus.mem_din, p.din);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]        v;
        logic [ADDR_W-1:0] a;
        reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.rd_bank = '0; bus.wr_mask = '0; bus.gfx_req = 0; bus.gfx_addr = '0;
        for (int i = 0; i < int'(PLANES); i++)
            for (int j = 0; j < 2**ADDR_W; j++) begin
                v = 8'($urandom); vram[i][j] = v; ref_mem[i][j] = v;
            end
        repeat (3) @(posedge clk);
        #1;
        chk("rst cpu_dout", bus.cpu_dout, 8'hFF);
        chk("rst gfx_data", bus.gfx_data, 48'h0);
        chk("rst mem_ce_n", bus.mem_ce_n, 6'b111111);
        chk("rst mem_we_n", bus.mem_we_n, 1'b1);
        chk("rst mem_addr", bus.mem_addr, 13'h0);
        chk("rst mem_din", bus.mem_din, 8'h0);
        chk("rst acks", {bus.cpu_ack, bus.gfx_ack}, 2'b00);
        reset = 1'b0;

        // CPU read of plane 3, then invalid bank
        vram[2][13'h0123] = 8'h5A; ref_mem[2][13'h0123] = 8'h5A;
        cpu_op(0, 13'h0123, 8'h00, 8'd3, 6'h00, 1, lat_c);
        chk("read latency", lat_c, 4);
        chk("read bank3 data", bus.cpu_dout, 8'h5A);
        cpu_op(0, 13'h0123, 8'h00, 8'd0, 6'h00, 1, lat_c);
        chk("read bank0 latency", lat_c, 4);
        chk("read bank0 data", bus.cpu_dout, 8'hFF);

        // Full-range gfx fetch with distinct bytes per plane
        for (int i = 0; i < int'(PLANES); i++) begin
            vram[i][13'h0000] = 8'(8'h10 + i); ref_mem[i][13'h0000] = 8'(8'h10 + i);
            vram[i][13'h1FFF] = 8'(8'hA0 + i); ref_mem[i][13'h1FFF] = 8'(8'hA0 + i);
        end
        gfx_op(13'h0000, lat_g);
        chk("gfx latency", lat_g, 4);
        chk("gfx data @0", bus.gfx_data, 48'h151413121110);
        gfx_op(13'h1FFF, lat_g);
        chk("gfx data @1FFF", bus.gfx_data, 48'hA5A4A3A2A1A0);

        // Masked write to planes 1, 3, 6 and read-back of all planes
        cpu_op(1, 13'h1FFF, 8'hC3, 8'd0, 6'b100101, 1, lat_c);
        chk("write latency", lat_c, 3);
        for (int i = 1; i <= 6; i++) begin
            cpu_op(0, 13'h1FFF, 8'h00, 8'(i), 6'h00, 1, lat_c);
            chk("readback", bus.cpu_dout, (i == 1 || i == 3 || i == 6) ? 8'hC3 : 8'(8'hA0 + i - 1));
        end
        cpu_op(1, 13'h0040, 8'h77, 8'd0, 6'b000000, 1, lat_c);
        chk("empty mask write latency", lat_c, 3);

        // Simultaneous requests: gfx first, CPU read after
        fork
            cpu_op(0, 13'h0123, 8'h00, 8'd3, 6'h00, 0, lat_c);
            gfx_op(13'h0777, lat_g);
        join
        chk("simul gfx latency", lat_g, 4);
        chk("simul cpu latency", lat_c, 8);

        // Reset during CPU issue
        @(posedge clk); #1;
        bus.cpu_wr = 0; bus.cpu_addr = 13'h0040; bus.rd_bank = 8'd3; bus.cpu_req = 1'b1;
        @(posedge clk); #1;
        chk("pre-reset issue ce_n", bus.mem_ce_n, 6'b111011);
        reset = 1'b1; #1;
        chk("reset ce_n", bus.mem_ce_n, 6'b111111);
        chk("reset we_n", bus.mem_we_n, 1'b1);
        chk("reset cpu_ack", bus.cpu_ack, 1'b0);
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        cpu_op(0, 13'h0123, 8'h00, 8'd3, 6'h00, 1, lat_c);
        chk("post-reset read latency", lat_c, 4);

        // Random serial traffic
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: a = 13'h0000;
                1: a = 13'h1FFF;
                2: a = 13'h0123;
                default: a = ADDR_W'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: begin gfx_op(a, lat_g); chk("rand gfx latency", lat_g, 4); end
                1: begin
                    cpu_op(0, a, 8'h00, 8'($urandom_range(0, 8)), 6'h00, 1, lat_c);
                    chk("rand read latency", lat_c, 4);
                end
                default: begin
                    cpu_op(1, a, 8'($urandom), 8'($urandom), PLANES'($urandom), 1, lat_c);
                    chk("rand write latency", lat_c, 3);
                end
            endcase
        end

        // Random concurrent traffic, disjoint address halves
        fork
            for (int n = 0; n < 25; n++) begin
                int l;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                if ($urandom_range(0, 1) == 1)
                    cpu_op(1, ADDR_W'($urandom) | 13'h1000, 8'($urandom), 8'd0, PLANES'($urandom), 0, l);
                else
                    cpu_op(0, ADDR_W'($urandom) | 13'h1000, 8'h00, 8'($urandom_range(0, 7)), 6'h00, 0, l);
            end
            for (int n = 0; n < 25; n++) begin
                int l;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                gfx_op(ADDR_W'($urandom) & 13'h0FFF, l);
            end
        join

        // Continuous gfx demand with a pending CPU read
        hold_addr = 13'h0AAA; hold_exp = gfx_ref(hold_addr); hold_mode = 1;
        @(posedge clk); #1;
        bus.gfx_addr = hold_addr; bus.gfx_req = 1'b1;
        bus.cpu_wr = 0; bus.cpu_addr = 13'h0123; bus.rd_bank = 8'd3; bus.cpu_req = 1'b1;
        cpu_q.push_back('{rd: 1, data: ref_mem[2][13'h0123]});
        cpu_port_q.push_back('{we_n: 1'b1, ce_n: 6'b111011, addr: 13'h0123, din: 8'h00});
        n_gfx = 0; got_cpu = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.gfx_ack) n_gfx++;
            if (bus.cpu_ack) begin got_cpu = 1; break; end
        end
`ifdef VRAM_ARB_FAIR_EN
        chk("fair cpu served", got_cpu, 1);
        chk("fair gfx grants before cpu", n_gfx, 4);
        @(posedge clk); #1;
        bus.gfx_req = 1'b0; bus.cpu_req = 1'b0;
`else
        chk("strict cpu starved", got_cpu, 0);
        chk("strict gfx grants", n_gfx, 20);
        @(posedge clk); #1;
        bus.gfx_req = 1'b0;
        got_cpu = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin got_cpu = 1; break; end
        end
        chk("strict cpu served after gfx drop", got_cpu, 1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
`endif
        repeat (10) @(posedge clk);
        hold_mode = 0;
        chk("cpu queue drained", cpu_q.size(), 0);
        chk("gfx queue drained", gfx_q.size(), 0);
        chk("port queues drained", cpu_port_q.size() + gfx_port_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
